// File: rtl/tsc_output_display.sv
// Display front-end for the TSC CPU: 4-digit multiplexed hex 7-segment display,
// 8 PC LEDs and a debounced single-step button pulse.
module tsc_output_display #(
  parameter int unsigned REFRESH_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned SEG_ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_in,
  input  logic [7:0]  pc_in,
  input  logic        freeze,
  input  logic        step_btn,
  output logic        step_pulse,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  led
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  // Polarity masks: XOR an active-high pattern to get pin levels.
  localparam logic [6:0] SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} deb_state_t;

  logic [15:0]   data_snap;
  logic [7:0]    pc_snap;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    digit;
  logic [1:0]    sync;
  logic          btn_s;
  logic [DW-1:0] deb_cnt;
  deb_state_t    deb_state;
  logic [3:0]    nib_c;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign nib_c = data_snap[{digit, 2'b00} +: 4];
  assign btn_s = sync[1];

  // Snapshot of CPU outputs, held while frozen; LEDs follow one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_snap <= '0;
      pc_snap   <= '0;
      led       <= '0;
    end else begin
      if (!freeze) begin
        data_snap <= data_in;
        pc_snap   <= pc_in;
      end
      led <= pc_snap;
    end
  end

  // Digit scan; an/seg/dp share one register stage so they switch together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt <= '0;
      digit   <= '0;
      an      <= 4'hF;
      seg     <= SEG_POL;
      dp      <= DP_OFF;
    end else begin
      if (ref_cnt == REF_LAST) begin
        ref_cnt <= '0;
        digit   <= digit + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + RW'(1);
      end
      an  <= ~(4'b0001 << digit);
      seg <= hex7(nib_c) ^ SEG_POL;
      dp  <= (freeze && (digit == 2'd3)) ? ~DP_OFF : DP_OFF;
    end
  end

  // Step button: synchronizer plus press/release debounce with a saturating counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync       <= '0;
      deb_state  <= IDLE;
      deb_cnt    <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync       <= {sync[0], step_btn};
      step_pulse <= 1'b0;
      case (deb_state)
        IDLE: begin
          if (btn_s) begin
            deb_state <= ARMING;
            deb_cnt   <= '0;
          end
        end
        ARMING: begin
          if (!btn_s) begin
            deb_state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            deb_state  <= PRESSED;
            step_pulse <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            deb_state <= RELEASING;
            deb_cnt   <= '0;
          end
        end
        RELEASING: begin
          if (btn_s) begin
            deb_state <= PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            deb_state <= IDLE;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: deb_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsc_output_display.sv
// Randomized self-checking bench for tsc_output_display against a cycle-level
// behavioural model (scan position from elapsed cycles, debounce as run lengths).
module tb_tsc_output_display;

  localparam int unsigned RDIV = 4;
  localparam int unsigned DEB  = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic [7:0]  pc_in;
  logic        freeze;
  logic        step_btn;
  logic        step_pulse;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  led;

  tsc_output_display #(
    .REFRESH_DIV(RDIV), .DEBOUNCE_CYCLES(DEB), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .pc_in(pc_in),
    .freeze(freeze), .step_btn(step_btn), .step_pulse(step_pulse),
    .an(an), .seg(seg), .dp(dp), .led(led)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [6:0]  hex_tbl [16];
  logic [15:0] m_data;
  logic [7:0]  m_pc;
  int          m_edges;
  logic        m_h1, m_h2;
  logic        m_pressed;
  int          m_run;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [7:0]  e_led;
  logic        e_pulse;
  int          pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_pc = '0; m_edges = 0;
    m_h1 = 1'b0; m_h2 = 1'b0; m_pressed = 1'b0; m_run = 0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_led = '0; e_pulse = 1'b0;
  endtask

  // One clock: capture pre-edge inputs, advance the model, compare 1 time unit later.
  task automatic tick();
    logic [15:0] d;
    logic [7:0]  p;
    logic        f, b, bs;
    int          idx;
    d = data_in; p = pc_in; f = freeze; b = step_btn;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      m_edges++;
      idx   = ((m_edges - 1) / int'(RDIV)) % 4;
      e_an  = ~(4'b0001 << idx);
      e_seg = ~hex_tbl[m_data[idx*4 +: 4]];
      e_dp  = !(f && idx == 3);
      e_led = m_pc;
      // Debounced level flips after DEB+1 consecutive sightings of the new level.
      bs = m_h2;
      e_pulse = 1'b0;
      if (bs != m_pressed) begin
        m_run++;
        if (m_run == int'(DEB) + 1) begin
          m_pressed = bs;
          m_run = 0;
          e_pulse = bs;
        end
      end else begin
        m_run = 0;
      end
      m_h2 = m_h1;
      m_h1 = b;
      if (!f) begin
        m_data = d;
        m_pc   = p;
      end
    end
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("led", 32'(led), 32'(e_led));
    check("step_pulse", 32'(step_pulse), 32'(e_pulse));
    if (step_pulse) pulses++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();
    reset_n = 1'b0; data_in = '0; pc_in = '0; freeze = 1'b0; step_btn = 1'b0;

    // Reset values
    run(3);
    reset_n = 1'b1;

    // Free-running scan of 12AF
    data_in = 16'h12AF;
    run(20);

    // Frozen snapshot ignores new data; dp on digit 3
    freeze = 1'b1;
    run(2);
    data_in = 16'h0000;
    run(18);
    freeze = 1'b0;
    run(20);

    // Two held presses -> two pulses
    pulses = 0;
    step_btn = 1'b1; run(20);
    step_btn = 1'b0; run(12);
    step_btn = 1'b1; run(20);
    step_btn = 1'b0; run(14);
    check("press_count", 32'(pulses), 32'd2);

    // Bounce shorter than debounce time -> no pulse
    pulses = 0;
    for (int r = 0; r < 2; r++) begin
      step_btn = 1'b1; run(3);
      step_btn = 1'b0; run(3);
    end
    run(12);
    check("bounce_count", 32'(pulses), 32'd0);

    // Reset while held in PRESSED; pulse re-issued after release of reset
    step_btn = 1'b1; run(14);
    pulses = 0;
    reset_n = 1'b0; run(2);
    reset_n = 1'b1;
    pc_in = 8'hA5;
    run(14);
    check("reset_press_count", 32'(pulses), 32'd1);
    check("led_after_reset", 32'(led), 32'h00A5);
    step_btn = 1'b0; run(12);

    // Randomized traffic
    for (int s = 0; s < 60; s++) begin
      int len;
      len = int'($urandom_range(1, 14));
      step_btn = 1'($urandom);
      for (int j = 0; j < len; j++) begin
        data_in = 16'($urandom);
        pc_in   = 8'($urandom);
        if ($urandom_range(0, 9) == 0) freeze = ~freeze;
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
